// File: rtl/queue_pkg.sv
// Shared definitions for the shop-queue ticket dispatcher and the service counters.
package queue_pkg;

  localparam int unsigned DEF_NUM_W    = 4;
  localparam int unsigned DEF_TIME_W   = 4;
  localparam int unsigned TICKET_FIRST = 1;

  typedef struct packed {
    logic [DEF_NUM_W-1:0]  num;
    logic [DEF_TIME_W-1:0] stime;
  } ticket_t;

endpackage

// File: rtl/ticket_fifo.sv
// Synchronous FIFO of ticket entries; dout shows the head, read-first on push+pop.
module ticket_fifo
  import queue_pkg::*;
#(
  parameter type         T     = ticket_t,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];

  // Push is gated on the registered full flag, so a pop in the same cycle never frees room early.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/queue_dispatcher.sv
// Ticket issuer: numbers arrivals, queues them, and loads each into the lowest idle counter.
module queue_dispatcher
  import queue_pkg::*;
#(
  parameter int unsigned NUM_W  = DEF_NUM_W,
  parameter int unsigned TIME_W = DEF_TIME_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned N_CNT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arr_valid,
  input  logic [TIME_W-1:0]          arr_time,
  output logic                       arr_ready,
  output logic [NUM_W-1:0]           arr_num,
  input  logic [N_CNT-1:0]           busy,
  output logic [N_CNT-1:0]           ld,
  output logic [NUM_W-1:0]           dn_out,
  output logic [TIME_W-1:0]          dt_out,
  output logic [$clog2(DEPTH):0]     q_len
);

  typedef struct packed {
    logic [NUM_W-1:0]  num;
    logic [TIME_W-1:0] stime;
  } entry_t;

  logic [NUM_W-1:0]   r_next_num;
  logic [NUM_W-1:0]   r_arr_num;
  logic [N_CNT-1:0]   r_ld;
  logic [NUM_W-1:0]   r_dn;
  logic [TIME_W-1:0]  r_dt;

  entry_t             w_din;
  entry_t             w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_disp;
  logic [N_CNT-1:0]   w_idle;
  logic [N_CNT-1:0]   w_sel;
  logic               w_found;

  assign arr_ready   = ~w_full;
  assign w_accept    = arr_valid & ~w_full;
  assign w_din.num   = r_next_num;
  assign w_din.stime = (arr_time == '0) ? TIME_W'(1) : arr_time;

  ticket_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .pop   (w_disp),
    .din   (w_din),
    .dout  (w_head),
    .count (q_len),
    .full  (w_full),
    .empty (w_empty)
  );

  // A counter whose load is still in flight has not raised busy yet; r_ld masks it.
  assign w_idle = ~busy & ~r_ld;
  assign w_disp = ~w_empty & (|w_idle);

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N_CNT; k++) begin
      if (w_idle[k] && !w_found) begin
        w_sel[k] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_num <= NUM_W'(TICKET_FIRST);
      r_arr_num  <= '0;
      r_ld       <= '0;
      r_dn       <= '0;
      r_dt       <= '0;
    end else begin
      if (w_accept) begin
        r_arr_num  <= r_next_num;
        r_next_num <= (r_next_num == '1) ? NUM_W'(TICKET_FIRST) : r_next_num + NUM_W'(1);
      end
      if (w_disp) begin
        r_ld <= w_sel;
        r_dn <= w_head.num;
        r_dt <= w_head.stime;
      end else begin
        r_ld <= '0;
        r_dn <= '0;
        r_dt <= '0;
      end
    end
  end

  assign arr_num = r_arr_num;
  assign ld      = r_ld;
  assign dn_out  = r_dn;
  assign dt_out  = r_dt;

endmodule

// File: tb/tb_queue_dispatcher.sv
// Scoreboard bench for queue_dispatcher with simple behavioural service counters.
module tb_queue_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       arr_valid;
  logic [3:0] arr_time;
  logic       arr_ready;
  logic [3:0] arr_num;
  logic [1:0] busy;
  logic [1:0] ld;
  logic [3:0] dn_out;
  logic [3:0] dt_out;
  logic [3:0] q_len;

  logic [1:0] hold;
  logic [1:0] bm;
  logic [3:0] cnt [2];

  int cyc     = 0;
  int acc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] ld;
    logic [3:0] dn;
    logic [3:0] dt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  queue_dispatcher #(
    .NUM_W  (4),
    .TIME_W (4),
    .DEPTH  (8),
    .N_CNT  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arr_valid (arr_valid),
    .arr_time  (arr_time),
    .arr_ready (arr_ready),
    .arr_num   (arr_num),
    .busy      (busy),
    .ld        (ld),
    .dn_out    (dn_out),
    .dt_out    (dt_out),
    .q_len     (q_len)
  );

  // Service counter model: busy from the edge that sees ld, for dt cycles.
  always @(posedge clk) begin
    if (rst) begin
      bm <= 2'b00;
      for (int k = 0; k < 2; k++) cnt[k] <= 4'd0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ld[k]) begin
          bm[k]  <= 1'b1;
          cnt[k] <= dt_out;
        end else if (bm[k]) begin
          cnt[k] <= cnt[k] - 4'd1;
          if (cnt[k] == 4'd1) bm[k] <= 1'b0;
        end
      end
    end
  end

  assign busy = bm | hold;

  always @(negedge clk) begin
    if (ld !== 2'b00) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ld: got ld=%b dn=%0d dt=%0d at cycle %0d, required no load", ld, dn_out, dt_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (ld !== mon_e.ld || dn_out !== mon_e.dn || dt_out !== mon_e.dt || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL dispatch_t%0d: got ld=%b dn=%0d dt=%0d cyc=%0d, required ld=%b dn=%0d dt=%0d cyc=%0d",
                   mon_e.dn, ld, dn_out, dt_out, cyc, mon_e.ld, mon_e.dn, mon_e.dt, mon_e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] l, input int dn, input int dt, input int c);
    exp_t e;
    e.ld  = l;
    e.dn  = 4'(dn);
    e.dt  = 4'(dt);
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic arrive(input int t, input int exp_num, input string name);
    arr_valid = 1'b1;
    arr_time  = 4'(t);
    step();
    arr_valid = 1'b0;
    acc       = cyc;
    check(name, arr_num, exp_num);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int  n  = 0;
    logic ok = 1'b0;
    while (n < 60 && !ok) begin
      step();
      n++;
      if (q_len == 4'd0 && ld == 2'b00 && busy == 2'b00) ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  initial begin
    int a0;
    int t;
    int en;
    rst       = 1'b1;
    arr_valid = 1'b0;
    arr_time  = 4'd0;
    hold      = 2'b00;
    step();
    step();
    rst = 1'b0;

    check("rst_ld", ld, 0);
    check("rst_dn", dn_out, 0);
    check("rst_dt", dt_out, 0);
    check("rst_arr_num", arr_num, 0);
    check("rst_q_len", q_len, 0);
    check("rst_arr_ready", arr_ready, 1);

    // single arrival
    arrive(5, 1, "t1_arr_num");
    push_exp(2'b01, 1, 5, acc + 1);
    check("t1_q_len_acc", q_len, 1);
    check("t1_no_bypass", ld, 0);
    step();
    check("t1_q_len_pop", q_len, 0);
    wait_idle("t1_idle");

    // three arrivals, third waits for counter 0
    do_reset();
    arrive(3, 1, "t2_arr1");
    a0 = acc;
    push_exp(2'b01, 1, 3, a0 + 1);
    arrive(4, 2, "t2_arr2");
    push_exp(2'b10, 2, 4, a0 + 2);
    arrive(2, 3, "t2_arr3");
    push_exp(2'b01, 3, 2, a0 + 6);
    wait_idle("t2_idle");

    // fill with both counters held busy
    do_reset();
    hold = 2'b11;
    for (int i = 1; i <= 8; i++) arrive(i, i, "t3_arr_num");
    check("t3_q_len_full", q_len, 8);
    check("t3_ready_full", arr_ready, 0);
    arr_valid = 1'b1;
    arr_time  = 4'd9;
    step();
    check("t3_refused_num", arr_num, 8);
    check("t3_refused_q_len", q_len, 8);
    hold = 2'b10;
    push_exp(2'b01, 1, 1, cyc + 1);
    step();
    check("t3_refused_with_pop", arr_num, 8);
    check("t3_q_len_pop", q_len, 7);
    arr_valid = 1'b0;
    hold      = 2'b11;
    check("t3_ready_after_pop", arr_ready, 1);
    arrive(9, 9, "t3_next_num");
    check("t3_q_len_refill", q_len, 8);

    // numbering wrap, last one with arr_time 0
    do_reset();
    hold = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      t  = (i == 16) ? 0 : (i % 3) + 1;
      en = (i <= 15) ? i : 1;
      arrive(t, en, "t4_arr_num");
      push_exp(2'b01, en, (t == 0) ? 1 : t, acc + 1);
      wait_idle("t4_idle");
    end

    // reset with tickets queued and a load in flight
    do_reset();
    hold = 2'b11;
    for (int i = 1; i <= 5; i++) arrive(7, i, "t6_arr_num");
    hold = 2'b10;
    push_exp(2'b01, 1, 7, cyc + 1);
    step();
    check("t6_ld_active", ld, 1);
    check("t6_q_len_before", q_len, 4);
    rst  = 1'b1;
    hold = 2'b00;
    step();
    check("t6_rst_ld", ld, 0);
    check("t6_rst_q_len", q_len, 0);
    check("t6_rst_ready", arr_ready, 1);
    check("t6_rst_dn", dn_out, 0);
    check("t6_rst_dt", dt_out, 0);
    rst = 1'b0;
    arrive(2, 1, "t6_first_after_rst");
    push_exp(2'b01, 1, 2, acc + 1);
    wait_idle("t6_idle");

    step();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
